// File: rtl/softmax_norm.sv
// softmax_norm: normalizes N_CLASS Q5.10 exp terms into probabilities (term << 10) / sum
// Ports: CLK/RST clock and async active-high reset; data/in_valid exp-term input stream;
// output_data/out_index/out_last/out_valid probability stream held until out_ready;
// busy high while dividing or presenting; drop pulses when a sample arrives while busy.
module softmax_norm #(
    parameter int N_CLASS = 4,
    parameter int IDX_W   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      data,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [15:0]      output_data,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             drop
);
    localparam logic [1:0] S_COL = 2'd0;
    localparam logic [1:0] S_DIV = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASS - 1);
    localparam logic [15:0] EVEN = 16'(1024 / N_CLASS);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_sum;
    logic [14:0]      r_buf [2**IDX_W];
    logic [4:0]       r_it;
    logic [31:0]      r_rem;
    logic [24:0]      r_dvd;
    logic [14:0]      r_q;
    logic [15:0]      r_out;
    logic             r_valid;
    logic             r_drop;

    logic [14:0] w_clamp;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_n;
    logic [15:0] w_q_n;

    // Negative terms contribute nothing; bit 15 set means negative in Q5.10.
    assign w_clamp = data[15] ? 15'd0 : data[14:0];
    // One restoring-division step: bring down the next dividend bit and try subtracting.
    assign w_trial = {r_rem, r_dvd[24]};
    assign w_ge    = w_trial >= {1'b0, r_sum};
    assign w_rem_n = w_ge ? 32'(w_trial - {1'b0, r_sum}) : w_trial[31:0];
    assign w_q_n   = {r_q, w_ge};

    assign output_data = r_out;
    assign out_valid   = r_valid;
    assign out_index   = r_idx;
    assign out_last    = r_valid && (r_idx == LAST);
    assign busy        = r_state != S_COL;
    assign drop        = r_drop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_COL;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_it    <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_q     <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < 2**IDX_W; i++) r_buf[i] <= '0;
        end else begin
            r_drop <= in_valid && (r_state != S_COL);
            case (r_state)
                S_COL: begin
                    if (in_valid) begin
                        r_buf[r_cnt] <= w_clamp;
                        r_sum        <= r_sum + 32'(w_clamp);
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_it    <= '0;
                            r_state <= S_DIV;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    // r_it==0 is a load cycle, then 25 quotient bits MSB-first.
                    if (r_it == 5'd0) begin
                        r_rem <= '0;
                        r_dvd <= {r_buf[r_idx], 10'd0};
                        r_q   <= '0;
                        r_it  <= 5'd1;
                    end else begin
                        r_rem <= w_rem_n;
                        r_dvd <= {r_dvd[23:0], 1'b0};
                        r_q   <= w_q_n[14:0];
                        if (r_it == 5'd25) begin
                            r_out   <= (r_sum == 32'd0) ? EVEN : w_q_n;
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            r_it <= r_it + 5'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == LAST) begin
                            r_idx   <= '0;
                            r_sum   <= '0;
                            r_state <= S_COL;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_it    <= '0;
                            r_state <= S_DIV;
                        end
                    end
                end
                default: r_state <= S_COL;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: scoreboard bench for softmax_norm with directed frames
module tb_softmax_norm;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] data;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] output_data;
    logic        out_valid;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        drop;

    typedef struct {
        int val;
        int idx;
        int last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    softmax_norm #(.N_CLASS(4), .IDX_W(4)) dut (
        .CLK(CLK), .RST(RST), .data(data), .in_valid(in_valid), .out_ready(out_ready),
        .output_data(output_data), .out_valid(out_valid), .out_index(out_index),
        .out_last(out_last), .busy(busy), .drop(drop)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input int v);
        in_valid = 1'b1;
        data     = 16'(v);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        int v[4];
        int s;
        exp_t e;
        v = '{a, b, c, d};
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] < 0) v[i] = 0;
            s += v[i];
        end
        for (int i = 0; i < 4; i++) begin
            e.val  = (s == 0) ? 256 : (v[i] * 1024) / s;
            e.idx  = i;
            e.last = (i == 3) ? 1 : 0;
            q.push_back(e);
        end
        drive(a);
        drive(b);
        drive(c);
        drive(d);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 0);
        q.delete();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", 32'(output_data), e.val);
                check("out_index", 32'(out_index), e.idx);
                check("out_last", 32'(out_last), e.last);
            end
        end
    end

    initial begin
        int n;
        RST       = 1'b1;
        in_valid  = 1'b0;
        data      = '0;
        out_ready = 1'b1;
        #1;
        check("rst_data", 32'(output_data), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_index", 32'(out_index), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        frame(1024, 1024, 1024, 1024);
        check("busy_div", 32'(busy), 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("latency", n, 26);
        wait_empty();
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(out_valid), 0);

        frame(3072, 1024, 0, 0);
        wait_empty();
        frame(0, 0, 0, 0);
        wait_empty();
        frame(-100, 1024, 1024, 1024);
        wait_empty();

        out_ready = 1'b0;
        frame(500, 1500, 2500, 3500);
        drive(777);
        check("drop_pulse", 32'(drop), 1);
        @(posedge CLK);
        #1;
        check("drop_end", 32'(drop), 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("hold_valid_rise", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(output_data), 64);
            check("hold_index", 32'(out_index), 0);
        end
        out_ready = 1'b1;
        wait_empty();

        drive(1024);
        drive(1024);
        drive(1024);
        drive(1024);
        repeat (5) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("arst_data", 32'(output_data), 0);
        check("arst_valid", 32'(out_valid), 0);
        check("arst_index", 32'(out_index), 0);
        check("arst_last", 32'(out_last), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_drop", 32'(drop), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        frame(2048, 0, 0, 0);
        wait_empty();

        drive(5000);
        drive(5000);
        RST = 1'b1;
        #2;
        RST = 1'b0;
        frame(1024, 3072, 0, 0);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
